// File: rtl/rmem_pkg.sv
// Shared definitions for the rmem write-back path.
// Widths, the hardwired-zero register and grant encodings.
package rmem_pkg;

   localparam int N_DEF    = 5;
   localparam int B_DEF    = 32;
   localparam int ZERO_REG = 0;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// The last_grant register is owned by the instantiating block.
module rr_arbiter2
   import rmem_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last_grant,
   output logic gnt_a,
   output logic gnt_b
);

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      unique case (1'b1)
         (req_a && req_b): begin
            // On a tie the side that did not win last time goes first
            if (last_grant == GRANT_B) gnt_a = 1'b1;
            else                       gnt_b = 1'b1;
         end
         (req_a && !req_b): gnt_a = 1'b1;
         (!req_a && req_b): gnt_b = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/rmem_wb_arbiter.sv
// Write-back arbiter for rmem: round-robin between ALU and load unit,
// one-entry write stage, and forwarding of the staged write onto reads.
module rmem_wb_arbiter
   import rmem_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int B = B_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         a_valid,
   input  logic [N-1:0] a_addr,
   input  logic [B-1:0] a_data,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [N-1:0] b_addr,
   input  logic [B-1:0] b_data,
   output logic         b_ready,
   input  logic [N-1:0] rd_addr1,
   input  logic [N-1:0] rd_addr2,
   output logic [B-1:0] rd_data1,
   output logic [B-1:0] rd_data2,
   output logic [N-1:0] rf_r_addr1,
   output logic [N-1:0] rf_r_addr2,
   input  logic [B-1:0] rf_r_data1,
   input  logic [B-1:0] rf_r_data2,
   output logic [N-1:0] rf_w_addr,
   output logic [B-1:0] rf_w_data,
   output logic         rf_write_en
);

   localparam logic [N-1:0] ZERO_ADDR = N'(ZERO_REG);

   logic         last_grant;
   logic         gnt_a;
   logic         gnt_b;
   logic         accept;
   logic [N-1:0] acc_addr;
   logic [B-1:0] acc_data;
   logic         stage_en;
   logic [N-1:0] stage_addr;
   logic [B-1:0] stage_data;

   rr_arbiter2 u_arb (
      .req_a      (a_valid),
      .req_b      (b_valid),
      .last_grant (last_grant),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b)
   );

   assign a_ready = gnt_a;
   assign b_ready = gnt_b;
   assign accept  = gnt_a | gnt_b;

   always_comb begin
      acc_addr = a_addr;
      acc_data = a_data;
      unique case (1'b1)
         gnt_a: begin
            acc_addr = a_addr;
            acc_data = a_data;
         end
         gnt_b: begin
            acc_addr = b_addr;
            acc_data = b_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= GRANT_B;
         stage_en   <= 1'b0;
         stage_addr <= '0;
         stage_data <= '0;
      end else begin
         // r0 writes are accepted but never reach rmem
         stage_en <= accept && (acc_addr != ZERO_ADDR);
         if (accept) begin
            stage_addr <= acc_addr;
            stage_data <= acc_data;
            last_grant <= gnt_b ? GRANT_B : GRANT_A;
         end
      end
   end

   assign rf_w_addr   = stage_addr;
   assign rf_w_data   = stage_data;
   assign rf_write_en = stage_en;

   assign rf_r_addr1 = rd_addr1;
   assign rf_r_addr2 = rd_addr2;

   assign rd_data1 = (stage_en && rd_addr1 == stage_addr) ? stage_data
                                                          : rf_r_data1;
   assign rd_data2 = (stage_en && rd_addr2 == stage_addr) ? stage_data
                                                          : rf_r_data2;

endmodule

// File: tb/tb_rmem_wb_arbiter.sv
// Directed bench for rmem_wb_arbiter with a behavioural rmem model.
module tb_rmem_wb_arbiter;

   localparam int N = 5;
   localparam int B = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         a_valid = 1'b0;
   logic [N-1:0] a_addr = '0;
   logic [B-1:0] a_data = '0;
   logic         a_ready;
   logic         b_valid = 1'b0;
   logic [N-1:0] b_addr = '0;
   logic [B-1:0] b_data = '0;
   logic         b_ready;
   logic [N-1:0] rd_addr1 = '0;
   logic [N-1:0] rd_addr2 = '0;
   logic [B-1:0] rd_data1;
   logic [B-1:0] rd_data2;
   logic [N-1:0] rf_r_addr1;
   logic [N-1:0] rf_r_addr2;
   logic [B-1:0] rf_r_data1;
   logic [B-1:0] rf_r_data2;
   logic [N-1:0] rf_w_addr;
   logic [B-1:0] rf_w_data;
   logic         rf_write_en;

   int checks = 0;
   int failures = 0;

   logic [B-1:0] mem [32];
   logic         mem_clr = 1'b0;
   logic         mem_load = 1'b0;
   logic [N-1:0] load_addr = '0;
   logic [B-1:0] load_data = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (mem_load) begin
         mem[load_addr] <= load_data;
      end else if (rf_write_en) begin
         mem[rf_w_addr] <= rf_w_data;
      end
   end

   assign rf_r_data1 = mem[rf_r_addr1];
   assign rf_r_data2 = mem[rf_r_addr2];

   rmem_wb_arbiter #(.N(N), .B(B)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_valid     (a_valid),
      .a_addr      (a_addr),
      .a_data      (a_data),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_addr      (b_addr),
      .b_data      (b_data),
      .b_ready     (b_ready),
      .rd_addr1    (rd_addr1),
      .rd_addr2    (rd_addr2),
      .rd_data1    (rd_data1),
      .rd_data2    (rd_data2),
      .rf_r_addr1  (rf_r_addr1),
      .rf_r_addr2  (rf_r_addr2),
      .rf_r_data1  (rf_r_data1),
      .rf_r_data2  (rf_r_data2),
      .rf_w_addr   (rf_w_addr),
      .rf_w_data   (rf_w_data),
      .rf_write_en (rf_write_en)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rf_write_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_wen got %0d exp 0", rf_write_en);
      end
      checks++;
      if (rf_w_addr !== 5'd0) begin
         failures++;
         $display("FAIL reset_waddr got %0d exp 0", rf_w_addr);
      end
      checks++;
      if (rf_w_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_wdata got %0d exp 0", rf_w_data);
      end
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got a=%0d b=%0d exp 0 0",
                  a_ready, b_ready);
      end
      @(negedge clk);
      mem_clr = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      a_valid = 1'b1;
      a_addr = 5'd3;
      a_data = 32'd34;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_ready got a=%0d b=%0d exp 1 0",
                  a_ready, b_ready);
      end
      tick();
      a_valid = 1'b0;
      #1;
      checks++;
      if (rf_write_en !== 1'b1 || rf_w_addr !== 5'd3 ||
          rf_w_data !== 32'd34) begin
         failures++;
         $display("FAIL single_stage got en=%0d a=%0d d=%0d exp 1 3 34",
                  rf_write_en, rf_w_addr, rf_w_data);
      end
      checks++;
      if (a_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_idle_ready got %0d exp 0", a_ready);
      end
      tick();
   endtask

   task automatic test_alternate();
      logic exp_a;
      do_reset();
      a_valid = 1'b1;
      a_addr = 5'd2;
      a_data = 32'd7;
      b_valid = 1'b1;
      b_addr = 5'd5;
      b_data = 32'd9;
      for (int i = 0; i < 4; i++) begin
         exp_a = (i % 2 == 0);
         #1;
         checks++;
         if (a_ready !== exp_a || b_ready !== !exp_a) begin
            failures++;
            $display("FAIL alt_grant%0d got a=%0d b=%0d exp %0d %0d",
                     i, a_ready, b_ready, exp_a, !exp_a);
         end
         tick();
         #1;
         checks++;
         if (rf_write_en !== 1'b1 ||
             rf_w_addr !== (exp_a ? 5'd2 : 5'd5) ||
             rf_w_data !== (exp_a ? 32'd7 : 32'd9)) begin
            failures++;
            $display("FAIL alt_stage%0d got en=%0d a=%0d d=%0d exp_a=%0d",
                     i, rf_write_en, rf_w_addr, rf_w_data, exp_a);
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_forward();
      mem_load = 1'b1;
      load_addr = 5'd3;
      load_data = 32'd11;
      tick();
      mem_load = 1'b0;
      a_valid = 1'b1;
      a_addr = 5'd3;
      a_data = 32'd34;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         failures++;
         $display("FAIL fwd_ready got %0d exp 1", a_ready);
      end
      tick();
      a_valid = 1'b0;
      rd_addr1 = 5'd3;
      rd_addr2 = 5'd3;
      #1;
      checks++;
      if (rd_data1 !== 32'd34 || rd_data2 !== 32'd34) begin
         failures++;
         $display("FAIL fwd_t1 got %0d %0d exp 34 34", rd_data1, rd_data2);
      end
      checks++;
      if (rf_r_data1 !== 32'd11 || rf_r_data2 !== 32'd11) begin
         failures++;
         $display("FAIL fwd_rf_old got %0d %0d exp 11 11",
                  rf_r_data1, rf_r_data2);
      end
      tick();
      a_valid = 1'b1;
      a_addr = 5'd2;
      a_data = 32'd88;
      #1;
      checks++;
      if (rf_r_data1 !== 32'd34 || rd_data1 !== 32'd34) begin
         failures++;
         $display("FAIL fwd_t2 got rf=%0d rd=%0d exp 34 34",
                  rf_r_data1, rd_data1);
      end
      tick();
      a_valid = 1'b0;
      rd_addr1 = 5'd2;
      rd_addr2 = 5'd3;
      #1;
      checks++;
      if (rd_data1 !== 32'd88 || rd_data2 !== 32'd34) begin
         failures++;
         $display("FAIL fwd_indep got %0d %0d exp 88 34", rd_data1, rd_data2);
      end
      tick();
   endtask

   task automatic test_zero();
      b_valid = 1'b1;
      b_addr = 5'd0;
      b_data = 32'd55;
      #1;
      checks++;
      if (b_ready !== 1'b1) begin
         failures++;
         $display("FAIL zero_ready got %0d exp 1", b_ready);
      end
      tick();
      b_valid = 1'b0;
      rd_addr1 = 5'd0;
      #1;
      checks++;
      if (rf_write_en !== 1'b0) begin
         failures++;
         $display("FAIL zero_wen got %0d exp 0", rf_write_en);
      end
      checks++;
      if (rd_data1 !== 32'd0) begin
         failures++;
         $display("FAIL zero_read got %0d exp 0", rd_data1);
      end
      tick();
      checks++;
      if (rf_r_data1 !== 32'd0) begin
         failures++;
         $display("FAIL zero_mem got %0d exp 0", rf_r_data1);
      end
   endtask

   task automatic test_back_to_back();
      b_valid = 1'b1;
      b_addr = 5'd4;
      b_data = 32'd1;
      #1;
      checks++;
      if (b_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_b_ready got %0d exp 1", b_ready);
      end
      tick();
      b_valid = 1'b0;
      a_valid = 1'b1;
      a_addr = 5'd4;
      a_data = 32'd2;
      rd_addr1 = 5'd4;
      #1;
      checks++;
      if (rf_write_en !== 1'b1 || rf_w_addr !== 5'd4 ||
          rf_w_data !== 32'd1) begin
         failures++;
         $display("FAIL b2b_stage1 got en=%0d a=%0d d=%0d exp 1 4 1",
                  rf_write_en, rf_w_addr, rf_w_data);
      end
      checks++;
      if (a_ready !== 1'b1 || rd_data1 !== 32'd1) begin
         failures++;
         $display("FAIL b2b_t1 got rdy=%0d rd=%0d exp 1 1",
                  a_ready, rd_data1);
      end
      tick();
      a_valid = 1'b0;
      #1;
      checks++;
      if (rf_w_data !== 32'd2 || rd_data1 !== 32'd2 ||
          rf_r_data1 !== 32'd1) begin
         failures++;
         $display("FAIL b2b_t2 got w=%0d rd=%0d rf=%0d exp 2 2 1",
                  rf_w_data, rd_data1, rf_r_data1);
      end
      tick();
      checks++;
      if (rf_r_data1 !== 32'd2 || rf_write_en !== 1'b0) begin
         failures++;
         $display("FAIL b2b_t3 got rf=%0d en=%0d exp 2 0",
                  rf_r_data1, rf_write_en);
      end
   endtask

   task automatic test_reset_mid();
      a_valid = 1'b1;
      a_addr = 5'd6;
      a_data = 32'd77;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         failures++;
         $display("FAIL rmid_ready got %0d exp 1", a_ready);
      end
      tick();
      a_valid = 1'b0;
      #1;
      checks++;
      if (rf_write_en !== 1'b1 || rf_w_addr !== 5'd6) begin
         failures++;
         $display("FAIL rmid_staged got en=%0d a=%0d exp 1 6",
                  rf_write_en, rf_w_addr);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rf_write_en !== 1'b0 || rf_w_addr !== 5'd0) begin
         failures++;
         $display("FAIL rmid_drop got en=%0d a=%0d exp 0 0",
                  rf_write_en, rf_w_addr);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      rd_addr1 = 5'd6;
      a_valid = 1'b1;
      a_addr = 5'd1;
      a_data = 32'd5;
      b_valid = 1'b1;
      b_addr = 5'd2;
      b_data = 32'd6;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL rmid_tie got a=%0d b=%0d exp 1 0", a_ready, b_ready);
      end
      checks++;
      if (rd_data1 !== 32'd0) begin
         failures++;
         $display("FAIL rmid_r6 got %0d exp 0", rd_data1);
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_forward();
      test_zero();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
